clock_divider_multi: RTL and testbench

- NUM_CH independent clock dividers driven from one input clock (clk_in).
- Each channel has a runtime-programmable integer period, a per-channel enable, a divided clock output and a one-cycle period-start tick.
- Divisor changes are double-buffered and take effect only at period boundaries, so outputs never produce runt pulses.
- A global sync input phase-aligns all channels; the block replaces fixed, compile-time single-output dividers in clocking and strobe generation.

---
 rtl/clkdiv_pkg.sv | 29 ++
 rtl/clkdiv_channel.sv | 111 +++++++++++
 rtl/clock_divider_multi.sv | 84 ++++++++
 tb/tb_clock_divider_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// CLKDIV_DUTY_EN adds a programmable high time to each request.
package clkdiv_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [31:0] high_time(
    input logic [31:0] div
  );
    return (div + 32'd1) >> 1;
  endfunction

  function automatic logic cfg_valid_chk(
`ifdef CLKDIV_DUTY_EN
    input logic [31:0] div,
    input logic [31:0] high
`else
    input logic [31:0] div
`endif
  );
`ifdef CLKDIV_DUTY_EN
    return (div >= MIN_DIV) && (high != 32'd0)
        && (high < div);
`else
    return div >= MIN_DIV;
`endif
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow period, pending flag.
// Ports: clk_in, reset, en, sync, wr/wr_div[/wr_high], pend, clk_out, tick.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0] wr_high,
`endif
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DEF_D =
    DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] d_q;
  logic [DIV_W-1:0] s_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] c_nxt;
  logic [DIV_W-1:0] h_cur;
  logic             p_q;
  logic             run_q;
  logic             wrap;

`ifdef CLKDIV_DUTY_EN
  localparam logic [DIV_W-1:0] DEF_H =
    DIV_W'(high_time(32'(DEFAULT_DIV)));
  logic [DIV_W-1:0] h_q;
  logic [DIV_W-1:0] hs_q;
  assign h_cur = h_q;
`else
  assign h_cur = DIV_W'(high_time(32'(d_q)));
`endif

  // sync forces a period start on running channels
  assign wrap  = sync
              || (cnt_q == d_q - DIV_W'(1));
  assign c_nxt = wrap ? '0 : cnt_q + DIV_W'(1);
  assign pend  = p_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      d_q     <= DEF_D;
      s_q     <= DEF_D;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      run_q   <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      h_q     <= DEF_H;
      hs_q    <= DEF_H;
`endif
    end else begin
      // wr only arrives with p_q low, so it never
      // collides with an apply below
      if (wr) begin
        s_q <= wr_div;
        p_q <= 1'b1;
`ifdef CLKDIV_DUTY_EN
        hs_q <= wr_high;
`endif
      end
      if (!run_q) begin
        if (p_q) begin
          d_q <= s_q;
          p_q <= 1'b0;
`ifdef CLKDIV_DUTY_EN
          h_q <= hs_q;
`endif
        end
        if (en) begin
          run_q   <= 1'b1;
          cnt_q   <= '0;
          clk_out <= 1'b1;
          tick    <= 1'b1;
        end else begin
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      end else if (!en) begin
        // shadow and pending survive a stop
        run_q   <= 1'b0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt_q   <= c_nxt;
        clk_out <= c_nxt < h_cur;
        tick    <= wrap;
        if (wrap && p_q) begin
          d_q <= s_q;
          p_q <= 1'b0;
`ifdef CLKDIV_DUTY_EN
          h_q <= hs_q;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH runtime-programmable clock dividers with config handshake.
// Ports: clk_in, reset, en, sync, cfg_*, clk_out, tick; CLKDIV_DUTY_EN adds cfg_high.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5,
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0]  cfg_high,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              ch_ok;
  logic              ok;
  logic              xfer;

  assign ch_ok = 32'(cfg_ch) < 32'(NUM_CH);
`ifdef CLKDIV_DUTY_EN
  assign ok = ch_ok
    && cfg_valid_chk(32'(cfg_div), 32'(cfg_high));
`else
  assign ok = ch_ok
    && cfg_valid_chk(32'(cfg_div));
`endif

  // out-of-range channels are accepted so they can error
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i))
        cfg_ready = !pend[i];
  end

  assign xfer = cfg_valid && cfg_ready;

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr[i] = xfer && ok && (cfg_ch == CH_W'(i));
  end

  always_ff @(posedge clk_in) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= xfer && !ok;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
`ifdef CLKDIV_DUTY_EN
      .wr_high (cfg_high),
`endif
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized bench for clock_divider_multi against a timestamp model.
// Build with CLKDIV_DUTY_EN to exercise the programmable high time.
module tb_clock_divider_multi;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
`ifdef CLKDIV_DUTY_EN
  logic [15:0] cfg_high;
`endif
  logic        cfg_err;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int total = 0;
  int bad   = 0;

  // model: per channel, period length and start timestamp
  int D[4], S[4], HD[4], HS[4], t0[4];
  bit P[4], run[4];
  int t = 0;
  logic [3:0] eo = '0, et = '0;
  logic       ee = 1'b0;

  always #5 clk_in = ~clk_in;

  clock_divider_multi dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_high  (cfg_high),
`endif
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h",
               tag, t, got, exp);
    end
  endtask

  function automatic int hi(input int i);
`ifdef CLKDIV_DUTY_EN
    return HD[i];
`else
    return (D[i] + 1) / 2;
`endif
  endfunction

  task automatic model_edge();
    bit acc, okv;
    t++;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        D[i] = 5; S[i] = 5; HD[i] = 3; HS[i] = 3;
        P[i] = 0; run[i] = 0; t0[i] = 0;
      end
      eo = '0; et = '0; ee = 1'b0;
      return;
    end
    acc = cfg_valid && !P[cfg_ch];
    okv = cfg_div >= 2;
`ifdef CLKDIV_DUTY_EN
    okv = okv && cfg_high != 0 && cfg_high < cfg_div;
`endif
    ee = acc && !okv;
    for (int i = 0; i < 4; i++) begin
      if (!run[i]) begin
        if (P[i]) begin
          D[i] = S[i]; HD[i] = HS[i]; P[i] = 0;
        end
        if (en[i]) begin
          run[i] = 1; t0[i] = t;
        end
      end else if (!en[i]) begin
        run[i] = 0;
      end else if (sync || t - t0[i] == D[i]) begin
        t0[i] = t;
        if (P[i]) begin
          D[i] = S[i]; HD[i] = HS[i]; P[i] = 0;
        end
      end
      eo[i] = run[i] && (t - t0[i]) < hi(i);
      et[i] = run[i] && t == t0[i];
      if (acc && okv && cfg_ch == 2'(i)) begin
        S[i] = int'(cfg_div);
`ifdef CLKDIV_DUTY_EN
        HS[i] = int'(cfg_high);
`endif
        P[i] = 1;
      end
    end
  endtask

  task automatic step();
    #1;
    if (!reset)
      chk("cfg_ready", 32'(cfg_ready),
          32'(!P[cfg_ch]));
    @(posedge clk_in);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'(eo));
    chk("tick", 32'(tick), 32'(et));
    chk("cfg_err", 32'(cfg_err), 32'(ee));
  endtask

  task automatic cfg(input int ch, input int div,
                     input int high);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(div);
`ifdef CLKDIV_DUTY_EN
    cfg_high  = 16'(high);
`else
    if (high < 0) $display("note: negative high");
`endif
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLKDIV_DUTY_EN
    cfg_high = '0;
`endif
    repeat (3) step();
    reset = 1'b0;
    step();
    // channel 0 alone at the default period
    en = 4'b0001;
    repeat (16) step();
    // channel 1: retune mid-period
    en = 4'b0011;
    repeat (3) step();
    cfg(1, 8, 4);
    repeat (24) step();
    // rejected requests
    cfg(2, 1, 1);
    step();
    cfg(3, 0, 0);
    cfg(3, 10, 10);
    repeat (3) step();
    // channel 2 to D=7 while idle, then sync
    en = 4'b0001;
    step();
    cfg(2, 7, 3);
    step();
    en = 4'b0101;
    repeat (9) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (12) step();
    // reset with an update pending
    cfg(0, 9, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (12) step();
    // duty case (plain build just sees 10/5)
    cfg(0, 10, 2);
    repeat (25) step();
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0)
        en = en ^ 4'(1 << $urandom_range(0, 3));
      sync      = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = 16'($urandom_range(0, 12));
`ifdef CLKDIV_DUTY_EN
      cfg_high  = 16'($urandom_range(0, 12));
`endif
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
